// File: rtl/memory_pkg.sv
// Shared types and default constants for the memory-game turn controller.
package memory_pkg;

    localparam int N_CARDS_DEFAULT   = 16;
    localparam int SYM_W_DEFAULT     = 3;
    localparam int TURN_SECS_DEFAULT = 15;
    localparam int HOLD_SECS_DEFAULT = 2;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PICK1   = 4'd1,
        ST_FETCH1  = 4'd2,
        ST_CAP1    = 4'd3,
        ST_PICK2   = 4'd4,
        ST_FETCH2  = 4'd5,
        ST_CAP2    = 4'd6,
        ST_HOLD    = 4'd7,
        ST_RESOLVE = 4'd8,
        ST_TOUT    = 4'd9
    } turn_state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'b00,
        RES_MATCH   = 2'b01,
        RES_MISS    = 2'b10,
        RES_TIMEOUT = 2'b11
    } turn_result_t;

endpackage

// File: rtl/turn_controller_sec_countdown.sv
// Loadable seconds down-counter: counts enabled tick_1s pulses down to zero
// and flags the last second so the owner can act on the final tick.
module sec_countdown
    import memory_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         tick_i,
    output logic [W-1:0] count_o,
    output logic         at_one_o
);

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: a load wins, otherwise decrement on enabled ticks and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && tick_i && (count_q != ZERO)) begin
            count_d = count_q - ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_one_o = (count_q == ONE);

endmodule

// File: rtl/turn_controller.sv
// One player's turn: cursor movement, two card selections with a board-memory
// fetch each, pair comparison, timed reveal, then match/miss/timeout resolution.
module turn_controller
    import memory_pkg::*;
#(
    parameter int N_CARDS   = N_CARDS_DEFAULT,
    parameter int SYM_W     = SYM_W_DEFAULT,
    parameter int TURN_SECS = TURN_SECS_DEFAULT,
    parameter int HOLD_SECS = HOLD_SECS_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick_1s,
    input  logic                       start,
    input  logic                       clr_board,
    input  logic                       btn_next,
    input  logic                       btn_sel,
    output logic [$clog2(N_CARDS)-1:0] sym_addr,
    input  logic [SYM_W-1:0]           sym_data,
    output logic [$clog2(N_CARDS)-1:0] cursor,
    output logic [N_CARDS-1:0]         face_up,
    output logic [N_CARDS-1:0]         matched,
    output logic [1:0]                 n_sel,
    output logic [3:0]                 time_left,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 result,
    output logic                       all_matched
);

    localparam int IDX_W = $clog2(N_CARDS);
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    turn_state_t        state_q, state_d;
    logic [IDX_W-1:0]   cursor_q, cursor_d;
    logic [IDX_W-1:0]   sym_addr_q, sym_addr_d;
    logic [IDX_W-1:0]   idx1_q, idx1_d;
    logic [SYM_W-1:0]   sym1_q, sym1_d;
    logic               hit_q, hit_d;
    logic [N_CARDS-1:0] revealed_q, revealed_d;
    logic [N_CARDS-1:0] matched_q, matched_d;
    logic [N_CARDS-1:0] face_up_q;
    logic [1:0]         n_sel_q, n_sel_d;
    turn_result_t       result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               all_matched_q;

    logic               turn_load_s, turn_en_s, turn_at_one_s;
    logic               hold_load_s, hold_en_s, hold_at_one_s;
    logic [3:0]         turn_count_s;
    logic [3:0]         hold_count_s;
    logic               sel_ok_s;

    // Turn timer: loaded at start, runs only while the player is picking.
    sec_countdown #(.W(4)) u_turn_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (turn_load_s),
        .load_val_i (4'(TURN_SECS)),
        .en_i       (turn_en_s),
        .tick_i     (tick_1s),
        .count_o    (turn_count_s),
        .at_one_o   (turn_at_one_s)
    );

    // Reveal-hold timer: loaded when the second symbol is compared.
    sec_countdown #(.W(4)) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (hold_load_s),
        .load_val_i (4'(HOLD_SECS)),
        .en_i       (hold_en_s),
        .tick_i     (tick_1s),
        .count_o    (hold_count_s),
        .at_one_o   (hold_at_one_s)
    );

    // A select is legal on an unmatched card that is not the first pick of this turn.
    assign sel_ok_s = btn_sel && !matched_q[cursor_q] &&
                      ((state_q == ST_PICK1) || (cursor_q != idx1_q));

    // Next-state and datapath updates for the turn sequence.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        sym_addr_d  = sym_addr_q;
        idx1_d      = idx1_q;
        sym1_d      = sym1_q;
        hit_d       = hit_q;
        revealed_d  = revealed_q;
        matched_d   = matched_q;
        n_sel_d     = n_sel_q;
        result_d    = result_q;
        turn_load_s = 1'b0;
        turn_en_s   = 1'b0;
        hold_load_s = 1'b0;
        hold_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_PICK1;
                    n_sel_d     = 2'd0;
                    result_d    = RES_NONE;
                    turn_load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
                if (clr_board) begin
                    matched_d = {N_CARDS{1'b0}};
                end else begin
                    matched_d = matched_q;
                end
            end
            ST_PICK1, ST_PICK2: begin
                turn_en_s = 1'b1;
                if (btn_next) begin
                    cursor_d = cursor_q + IDX_ONE;
                end else begin
                    cursor_d = cursor_q;
                end
                // The final timer tick beats a selection in the same cycle.
                if (tick_1s && turn_at_one_s) begin
                    state_d  = ST_TOUT;
                    result_d = RES_TIMEOUT;
                end else if (sel_ok_s) begin
                    sym_addr_d           = cursor_q;
                    revealed_d[cursor_q] = 1'b1;
                    n_sel_d              = n_sel_q + 2'd1;
                    if (state_q == ST_PICK1) begin
                        idx1_d  = cursor_q;
                        state_d = ST_FETCH1;
                    end else begin
                        state_d = ST_FETCH2;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH1: begin
                state_d = ST_CAP1;
            end
            ST_CAP1: begin
                sym1_d  = sym_data;
                state_d = ST_PICK2;
            end
            ST_FETCH2: begin
                state_d = ST_CAP2;
            end
            ST_CAP2: begin
                hit_d       = (sym_data == sym1_q);
                hold_load_s = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                hold_en_s = 1'b1;
                if (tick_1s && hold_at_one_s) begin
                    state_d  = ST_RESOLVE;
                    result_d = hit_q ? RES_MATCH : RES_MISS;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RESOLVE: begin
                if (hit_q) begin
                    matched_d = matched_q | revealed_q;
                end else begin
                    matched_d = matched_q;
                end
                revealed_d = {N_CARDS{1'b0}};
                state_d    = ST_IDLE;
            end
            ST_TOUT: begin
                revealed_d = {N_CARDS{1'b0}};
                state_d    = ST_IDLE;
            end
            default: begin
                revealed_d = {N_CARDS{1'b0}};
                state_d    = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_RESOLVE) || (state_d == ST_TOUT);
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs; face_up/all_matched track the new vectors.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cursor_q      <= {IDX_W{1'b0}};
            sym_addr_q    <= {IDX_W{1'b0}};
            idx1_q        <= {IDX_W{1'b0}};
            sym1_q        <= {SYM_W{1'b0}};
            hit_q         <= 1'b0;
            revealed_q    <= {N_CARDS{1'b0}};
            matched_q     <= {N_CARDS{1'b0}};
            face_up_q     <= {N_CARDS{1'b0}};
            n_sel_q       <= 2'd0;
            result_q      <= RES_NONE;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            all_matched_q <= 1'b0;
        end else begin
            cursor_q      <= cursor_d;
            sym_addr_q    <= sym_addr_d;
            idx1_q        <= idx1_d;
            sym1_q        <= sym1_d;
            hit_q         <= hit_d;
            revealed_q    <= revealed_d;
            matched_q     <= matched_d;
            face_up_q     <= matched_d | revealed_d;
            n_sel_q       <= n_sel_d;
            result_q      <= result_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            all_matched_q <= &matched_d;
        end
    end

    assign cursor      = cursor_q;
    assign sym_addr    = sym_addr_q;
    assign face_up     = face_up_q;
    assign matched     = matched_q;
    assign n_sel       = n_sel_q;
    assign time_left   = turn_count_s;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign all_matched = all_matched_q;

endmodule

// File: doc/turn_controller.md
# turn_controller

Sequences one player's turn in the memory game: moves the board cursor, accepts two card selections, fetches each card's symbol from the board memory, and compares the pair. It holds the pair face-up for a fixed reveal time, then marks the pair matched or flips it back. It enforces the per-turn time limit. It sits between the button/debounce logic and the game-level FSM: the FSM pulses `start` and consumes `done`/`result`, and the VGA renderer consumes `cursor`, `face_up` and `matched`.

## Interface
- `N_CARDS`, default 16: number of cards on the board; must be a power of two.
- `SYM_W`, default 3: symbol width in bits.
- `TURN_SECS`, default 15: seconds allowed to complete both selections.
- `HOLD_SECS`, default 2: seconds the second card stays revealed before resolution.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-low reset.
- `tick_1s`  in  1  one-cycle pulse per second, from the seconds counter.
- `start`  in  1  pulse that begins a turn; ignored unless IDLE.
- `clr_board`  in  1  clears `matched`; honoured only in IDLE.
- `btn_next`  in  1  one-cycle pulse that advances the cursor.
- `btn_sel`  in  1  one-cycle pulse that selects the card under the cursor.
- `sym_addr`  out  log2(N_CARDS)  registered board-memory read address.
- `sym_data`  in  SYM_W  board-memory symbol, one-cycle read latency.
- `cursor`  out  log2(N_CARDS)  current cursor position.
- `face_up`  out  N_CARDS  cards visible: `matched` OR cards revealed this turn.
- `matched`  out  N_CARDS  permanently matched cards.
- `n_sel`  out  2  cards selected this turn (0, 1 or 2).
- `time_left`  out  4  remaining turn seconds.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of turn.
- `result`  out  2  00 none, 01 match, 10 miss, 11 timeout; valid from `done` until the next `start`.
- `all_matched`  out  1  AND-reduction of `matched`.

## Operation
States: IDLE, PICK1, FETCH1, CAP1, PICK2, FETCH2, CAP2, HOLD, RESOLVE, TOUT.

- **IDLE**
  - `start` loads `time_left`=TURN_SECS, sets `n_sel`=0 and `result`=00, then goes to PICK1.
  - `clr_board` sets `matched`=0.
- **PICK1 / PICK2 (cursor)**
  - `btn_next` sets cursor ← (cursor+1) mod N_CARDS.
  - `btn_next` is ignored in all other states.
- **PICK1 / PICK2 (select)**
  - `btn_sel` is accepted only if `matched[cursor]`=0 and, in PICK2, cursor≠idx1. Otherwise it is ignored.
  - On accept: idx ← cursor, `sym_addr` ← cursor, the revealed bit is set, `n_sel` increments, and the state goes to FETCHx.
  - If `btn_next` and `btn_sel` arrive in the same cycle, the select uses the pre-increment cursor and the cursor still advances.
- **FETCHx → CAPx**
  - Each is one cycle, unconditional.
  - CAP1 latches `sym1` ← `sym_data`, then goes to PICK2.
  - CAP2 registers `hit` = (`sym_data` == `sym1`), loads hold count = HOLD_SECS, then goes to HOLD.
- **HOLD**
  - Each `tick_1s` decrements the hold count.
  - A tick while the count is 1 goes to RESOLVE.
- **RESOLVE** (one cycle)
  - Asserts `done`.
  - If `hit`: `result`=01 and `matched` |= both bits. If not: `result`=10.
  - Clears the revealed bits, then goes to IDLE.
- **Turn timer**
  - Decrements on `tick_1s` only in PICK1/PICK2; frozen in all other states.
  - A tick while `time_left`=1 goes to TOUT and takes priority over a same-cycle `btn_sel`.
- **TOUT** (one cycle)
  - Asserts `done` with `result`=11.
  - Clears the revealed bits, leaves `matched` unchanged, then goes to IDLE.
- `start` while busy is ignored. `clr_board` while busy is ignored.

## Timing
- **Reset values:** state IDLE; `cursor`=0; `sym_addr`=0; `face_up`=0; `matched`=0; `n_sel`=0; `time_left`=0; `busy`=0; `done`=0; `result`=00; `all_matched`=0.
- **Reset mid-turn:** aborts the turn, clears everything above, and emits no `done`.
- **Memory read:**
  - `sym_addr` changes at the accept edge E0.
  - Memory registers at E1.
  - Controller samples `sym_data` at E2.
  - Selections are locked out for 2 cycles after each accept.
- **Second accept → `done`:** 2 cycles + HOLD_SECS ticks + 1 cycle.
- **Outputs:** all registered; `done` is high exactly one cycle (RESOLVE or TOUT).
- **Widths:** `time_left` is 4 bits, which requires TURN_SECS ≤ 15. Cursor wrap is natural modulo N_CARDS.
- **`all_matched`:** reflects `matched` in the same cycle it updates, i.e. the cycle after RESOLVE.

## Structure
- Package `memory_pkg`:
  - `turn_state_t` enum.
  - `turn_result_t` enum (RES_NONE, RES_MATCH, RES_MISS, RES_TIMEOUT).
  - Default constants N_CARDS, SYM_W, TURN_SECS, HOLD_SECS.
- One sub-module, `sec_countdown`: load value, enable, `tick_1s`, count output, `at_one` flag. It is instantiated twice, once for the turn timer and once for the hold counter.
- `turn_controller` holds the FSM, cursor, idx/`sym1` registers and the revealed/matched vectors.

## Test plan
- **Match:** board sym[3]=sym[7]=5. Start; select at cursor 3; next ×4; select; 2 ticks → `done`, `result`=01, `matched`=0x0088, `face_up`=0x0088.
- **Miss:** sym[0]=1, sym[1]=2. Select 0, next, select 1; during HOLD `face_up`=0x0003; after 2 ticks `result`=10, `face_up`=0x0000.
- **Timeout:** start, select card 0, then 15 ticks with no second select → `result`=11 on the 15th tick's following cycle, `face_up`=0, `n_sel` stays 1. A `btn_sel` on the 15th tick's cycle is ignored.
- **Illegal selects:** select an already-matched card, or re-select idx1 in PICK2 → `n_sel` unchanged, no `sym_addr` change.
- **Wrap and all-matched:** cursor wraps 15→0 with one `btn_next`. Match all 8 pairs → `all_matched`=1; `clr_board` in IDLE → `matched`=0.
- **Reset mid-turn:** `rst`=0 during HOLD → all outputs at reset values next cycle, no `done` pulse.
